serial_magnitude_comparator: RTL and testbench
==============================================

Name: serial_magnitude_comparator

Overview:
Multicycle magnitude comparator for the ALU compare path. It accepts two WIDTH-bit operands on a start pulse and walks them MSB-first, 2 bits per cycle, through an EQ/GT cascade. It resolves the cascade into isEqual, isGreater, isLessThan and isNotEqual flags for branch/compare consumers. Signed or unsigned interpretation is selected per operation.

Parameters:
WIDTH, 32, operand width in bits; must be even and >= 2.
DIGIT, 2, bits consumed per cycle; fixed at 2.

Ports:
clock  input  1  sole clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; latched with start
data_operandA  input  WIDTH  operand A; latched with start
data_operandB  input  WIDTH  operand B; latched with start
busy  output  1  high in RUN and DONE; start ignored while high
result_valid  output  1  one-cycle pulse when flags update
isEqual  output  1  A == B
isGreater  output  1  A > B
isLessThan  output  1  A < B
isNotEqual  output  1  A != B

Behaviour:
- Reset (synchronous, active-high): state IDLE; busy, result_valid, isEqual, isGreater, isLessThan and isNotEqual all 0; cascade eq=1, gt=0; counter 0. Reset during RUN or DONE aborts the operation with no result_valid.
- States: IDLE, RUN, DONE.
  - IDLE -> RUN on start=1.
  - RUN -> DONE after the last digit, or on early exit (see Optional Feature).
  - DONE -> IDLE unconditionally after one cycle.
- On the accepting edge, latch operands into shift registers sa and sb.
  - If signed_mode=1, invert bit WIDTH-1 of both operands (offset-binary), so the unsigned cascade gives the signed order.
  - Initialise eq=1, gt=0, counter=WIDTH/2.
- Each RUN edge takes the 2-bit digits a=sa[WIDTH-1:WIDTH-2] and b=sb[WIDTH-1:WIDTH-2]:
  - if eq=1: eq_next=(a==b), gt_next=(a>b);
  - if eq=0: eq_next=0, gt_next=gt (held);
  - shift sa and sb left by 2 and decrement counter.
- Transition to DONE on the edge that processes the digit when counter reaches 1.
- In DONE: result_valid=1 and flags are registered from final eq/gt:
  - isEqual=eq
  - isGreater=~eq&gt
  - isLessThan=~eq&~gt
  - isNotEqual=~eq
- Flags hold their values until the next DONE or reset. result_valid is 0 in all other states.
- Latency: start sampled at edge N; result_valid high from edge N+WIDTH/2+1 for one cycle (17 for WIDTH=32). Back-to-back: earliest next start is accepted on the edge after DONE.
- start asserted while busy=1 is dropped, with no queuing.
- Boundaries:
  - A=B=0 and A=B=all-ones give isEqual.
  - signed_mode does not affect equality.
  - A most-negative signed value compares less than every other value.

Optional Feature:
Macro CMP_EARLY_EXIT_EN.
- Defined: RUN -> DONE on the first edge where eq_next=0 (cascade resolved), or at counter end. Latency is k+1 edges, where k is the index (1-based, from MSB) of the first differing digit. Equal operands still take the full WIDTH/2.
- Undefined: always WIDTH/2 RUN cycles; latency is fixed.

Decomposition:
- Package cmp_pkg:
  - state encoding constants IDLE/RUN/DONE;
  - DIGIT=2;
  - function for counter width, clog2(WIDTH/2+1).
- One combinational sub-module, cmp_digit_slice:
  - inputs: eq_in, gt_in, 2-bit a, 2-bit b;
  - outputs: eq_out, gt_out;
  - implements the cascade step above.
- The top module holds the FSM, shift registers, counter and output registers.

Test Plan:
- Unsigned A=5, B=3, WIDTH=32 -> result_valid exactly 17 edges after start; isGreater=1, others 0; then busy=0.
- A=B=0xDEADBEEF, signed and unsigned -> isEqual=1, isNotEqual=0; 16 RUN cycles even with CMP_EARLY_EXIT_EN.
- A=0xFFFFFFFF, B=0x00000001: signed_mode=1 -> isLessThan=1; signed_mode=0 -> isGreater=1.
- A=0x80000000, B=0x7FFFFFFF, signed -> isLessThan=1; with CMP_EARLY_EXIT_EN, result_valid 2 edges after start, otherwise 17.
- start pulsed at RUN cycle 3 with different operands -> ignored; only the original result is reported; single result_valid pulse.
- reset asserted in RUN cycle 5 -> next edge: busy=0 and all flags 0, with no result_valid; a new start (A=1, B=2) then completes with isLessThan=1.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared types and constants for the serial magnitude comparator.
package cmp_pkg;

  localparam int unsigned DIGIT = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter must hold WIDTH/2 digits down to zero.
  function automatic int unsigned cnt_w(input int unsigned width);
    return $clog2(width / 2 + 1);
  endfunction

endpackage

// File: rtl/cmp_digit_slice.sv
// One MSB-first cascade step over a 2-bit digit pair.
module cmp_digit_slice
  import cmp_pkg::*;
(
  input  logic             eq_in,
  input  logic             gt_in,
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  output logic             eq_out,
  output logic             gt_out
);

  // Once a higher digit has decided the order, lower digits cannot change it.
  assign eq_out = eq_in & (a == b);
  assign gt_out = eq_in ? (a > b) : gt_in;

endmodule

// File: rtl/serial_magnitude_comparator.sv
// Multicycle MSB-first magnitude comparator, one 2-bit digit per cycle.
// Define CMP_EARLY_EXIT_EN to leave RUN as soon as the cascade resolves.
module serial_magnitude_comparator
  import cmp_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic             busy,
  output logic             result_valid,
  output logic             isEqual,
  output logic             isGreater,
  output logic             isLessThan,
  output logic             isNotEqual
);

  localparam int unsigned CNT_W = cnt_w(WIDTH);
  localparam logic [WIDTH-1:0] SIGN_MASK = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d;
  logic             eq_q, eq_d, gt_q, gt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_d, rv_d;
  logic             is_eq_d, is_gt_d, is_lt_d, is_ne_d;
  logic             slice_eq, slice_gt;

  cmp_digit_slice u_slice (
    .eq_in  (eq_q),
    .gt_in  (gt_q),
    .a      (sa_q[WIDTH-1 -: DIGIT]),
    .b      (sb_q[WIDTH-1 -: DIGIT]),
    .eq_out (slice_eq),
    .gt_out (slice_gt)
  );

  // State and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      sa_q         <= '0;
      sb_q         <= '0;
      eq_q         <= 1'b1;
      gt_q         <= 1'b0;
      cnt_q        <= '0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      isEqual      <= 1'b0;
      isGreater    <= 1'b0;
      isLessThan   <= 1'b0;
      isNotEqual   <= 1'b0;
    end else begin
      state_q      <= state_d;
      sa_q         <= sa_d;
      sb_q         <= sb_d;
      eq_q         <= eq_d;
      gt_q         <= gt_d;
      cnt_q        <= cnt_d;
      busy         <= busy_d;
      result_valid <= rv_d;
      isEqual      <= is_eq_d;
      isGreater    <= is_gt_d;
      isLessThan   <= is_lt_d;
      isNotEqual   <= is_ne_d;
    end
  end

  // Next-state, datapath and output logic.
  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    eq_d    = eq_q;
    gt_d    = gt_q;
    cnt_d   = cnt_q;
    rv_d    = 1'b0;
    is_eq_d = isEqual;
    is_gt_d = isGreater;
    is_lt_d = isLessThan;
    is_ne_d = isNotEqual;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          // Offset-binary: flipping the sign bit lets the unsigned cascade order signed values.
          sa_d    = data_operandA ^ (signed_mode ? SIGN_MASK : '0);
          sb_d    = data_operandB ^ (signed_mode ? SIGN_MASK : '0);
          eq_d    = 1'b1;
          gt_d    = 1'b0;
          cnt_d   = CNT_W'(WIDTH / 2);
        end
      end
      RUN: begin
        eq_d  = slice_eq;
        gt_d  = slice_gt;
        sa_d  = sa_q << DIGIT;
        sb_d  = sb_q << DIGIT;
        cnt_d = cnt_q - CNT_W'(1);
`ifdef CMP_EARLY_EXIT_EN
        if ((cnt_q == CNT_W'(1)) || !slice_eq) state_d = DONE;
`else
        if (cnt_q == CNT_W'(1)) state_d = DONE;
`endif
      end
      DONE: begin
        state_d = IDLE;
        rv_d    = 1'b1;
        is_eq_d = eq_q;
        is_gt_d = ~eq_q & gt_q;
        is_lt_d = ~eq_q & ~gt_q;
        is_ne_d = ~eq_q;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Self-checking bench for serial_magnitude_comparator (WIDTH=32), directed and random operations.
module tb_serial_magnitude_comparator;

  localparam int unsigned W = 32;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         signed_mode = 1'b0;
  logic [W-1:0] data_operandA = '0;
  logic [W-1:0] data_operandB = '0;
  logic         busy, result_valid, isEqual, isGreater, isLessThan, isNotEqual;

  int errors = 0;
  int checks = 0;

  serial_magnitude_comparator #(.WIDTH(W)) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .signed_mode   (signed_mode),
    .data_operandA (data_operandA),
    .data_operandB (data_operandB),
    .busy          (busy),
    .result_valid  (result_valid),
    .isEqual       (isEqual),
    .isGreater     (isGreater),
    .isLessThan    (isLessThan),
    .isNotEqual    (isNotEqual)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: {eq, gt, lt, ne} from plain integer comparison.
  function automatic logic [3:0] ref_flags(input logic [31:0] a, input logic [31:0] b, input logic sm);
    logic gt, eq;
    eq = (a == b);
    gt = sm ? ($signed(a) > $signed(b)) : (a > b);
    return {eq, gt, ~eq & ~gt, ~eq};
  endfunction

  // Reference: edges from the start edge to result_valid.
  function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b);
`ifdef CMP_EARLY_EXIT_EN
    for (int k = 1; k <= 16; k++)
      if (a[32-2*k +: 2] != b[32-2*k +: 2]) return k + 1;
`endif
    return 17;
  endfunction

  function automatic logic [3:0] flags();
    return {isEqual, isGreater, isLessThan, isNotEqual};
  endfunction

  // Launch one op; optionally inject a spurious start at RUN cycle inj (0 = none).
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic sm,
                       input int inj, input string tag);
    int lat;
    @(negedge clock);
    start = 1'b1; data_operandA = a; data_operandB = b; signed_mode = sm;
    @(posedge clock); #1;
    start = 1'b0;
    data_operandA = $urandom; data_operandB = $urandom; signed_mode = ~sm;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    lat = 0;
    while (lat < 40) begin
      start = (inj != 0 && lat == inj);
      @(posedge clock); #1;
      start = 1'b0;
      lat++;
      if (result_valid) break;
    end
    check({tag, "_latency"}, 32'(lat), 32'(ref_lat(a, b)));
    check({tag, "_flags"}, 32'(flags()), 32'(ref_flags(a, b, sm)));
    check({tag, "_busy_done"}, 32'(busy), 32'd0);
    @(posedge clock); #1;
    check({tag, "_rv_pulse"}, 32'(result_valid), 32'd0);
    check({tag, "_hold"}, 32'(flags()), 32'(ref_flags(a, b, sm)));
  endtask

  task automatic quiet_window(input int n, input string tag);
    int pulses = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
      if (result_valid) pulses++;
    end
    check({tag, "_no_extra_rv"}, 32'(pulses), 32'd0);
  endtask

  initial begin
    logic [31:0] ra, rb, x;
    logic        rs;
    int          lat;

    repeat (2) @(posedge clock);
    #1;
    check("reset_outputs", {26'd0, busy, result_valid, flags()}, 32'd0);
    reset = 1'b0;

    do_op(32'd5, 32'd3, 1'b0, 0, "u5_gt_3");
    do_op(32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 0, "eq_unsigned");
    do_op(32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 0, "eq_signed");
    do_op(32'h0, 32'h0, 1'b0, 0, "eq_zero");
    do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 0, "eq_ones");
    do_op(32'hFFFFFFFF, 32'h00000001, 1'b1, 0, "m1_vs_1_signed");
    do_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 0, "m1_vs_1_unsigned");
    do_op(32'h80000000, 32'h7FFFFFFF, 1'b1, 0, "minneg_vs_maxpos");
    do_op(32'h80000000, 32'hFFFFFFFF, 1'b1, 0, "minneg_vs_m1");
    do_op(32'h00000002, 32'h00000003, 1'b0, 0, "last_digit_lt");

    // Spurious start mid-run with equal operands so the run spans full length.
    x = $urandom;
    do_op(x, x, 1'b0, 3, "start_ignored");
    quiet_window(20, "start_ignored");

    // Reset in RUN cycle 5 aborts silently.
    x = $urandom;
    @(negedge clock);
    start = 1'b1; data_operandA = x; data_operandB = x; signed_mode = 1'b0;
    @(posedge clock); #1;
    start = 1'b0;
    for (int i = 1; i < 5; i++) begin
      @(posedge clock); #1;
    end
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("abort_state", {26'd0, busy, result_valid, flags()}, 32'd0);
    quiet_window(20, "abort");
    do_op(32'd1, 32'd2, 1'b0, 0, "after_abort");

    // Back-to-back: next start accepted on the edge after DONE.
    @(negedge clock);
    start = 1'b1; data_operandA = 32'd9; data_operandB = 32'd9; signed_mode = 1'b0;
    @(posedge clock); #1;
    lat = 0;
    while (lat < 40) begin
      @(posedge clock); #1;
      lat++;
      if (result_valid) break;
    end
    data_operandA = 32'd4; data_operandB = 32'd7;
    @(posedge clock); #1;
    start = 1'b0;
    check("b2b_accept_busy", 32'(busy), 32'd1);
    lat = 0;
    while (lat < 40) begin
      @(posedge clock); #1;
      lat++;
      if (result_valid) break;
    end
    check("b2b_latency", 32'(lat), 32'(ref_lat(32'd4, 32'd7)));
    check("b2b_flags", 32'(flags()), 32'(ref_flags(32'd4, 32'd7, 1'b0)));

    // Random operands, some forced equal or differing only in a low digit.
    for (int i = 0; i < 24; i++) begin
      ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
      case (i % 4)
        0: rb = ra;
        1: rb = ra ^ (32'h3 << (2 * $urandom_range(0, 15)));
        default: ;
      endcase
      do_op(ra, rb, rs, 0, "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
